alu_issue_ctrl: RTL and testbench

- Issue/writeback controller wrapped around the 8-bit combinational ALU.
- Accepts one operation per valid/ready handshake and reads operands from an internal 4-entry, 8-bit register file or an immediate.
- Drives the ALU x/y/sel inputs, captures the ALU result and zero flag, and writes the result back to the destination register.
- It is the stage directly upstream of the ALU (feeds it) and directly downstream of it (consumes its result).

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu.sv | 30 +++
 rtl/regfile_4x8.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue/writeback controller:
// datapath width, ALU select encodings and the controller FSM states.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
// Ports: x, y   operands
//        sel    operation (ADD/SUB/AND/OR), wrapping arithmetic
//        result operation result
//        zero   result == 0
module alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  import alu_pkg::*;

  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD: result = x + y;
      ALU_SUB: result = x - y;
      ALU_AND: result = x & y;
      ALU_OR:  result = x | y;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regfile_4x8.sv
// Small register file: two combinational read ports, one combinational
// debug read port, one synchronous write port; synchronous reset clears
// every entry.
// Ports: clk, rst          clock / synchronous active-high reset
//        ra_addr/ra_data   read port A
//        rb_addr/rb_data   read port B
//        dbg_addr/dbg_data debug read port
//        we/wa/wd          write enable / address / data
module regfile_4x8 #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around the combinational ALU. Accepts one
// operation per valid/ready handshake, reads operands from the internal
// register file (or an immediate), drives the ALU for one cycle, then
// writes the result back. One op every 3 cycles: IDLE -> EXEC -> WB.
// Ports: clk, rst                         clock / sync active-high reset
//        op_valid/op_ready                operation handshake
//        op_code/op_rd/op_rs/op_rt        operation fields
//        imm_en/imm                       immediate select / value for y
//        alu_x/alu_y/alu_sel              to the ALU
//        alu_result/alu_zero              from the ALU
//        done_valid/done_rd/done_data     writeback report (pulse in WB)
//        zero_flag                        zero flag of last completed op
//        dbg_addr/dbg_data                combinational register read
module alu_issue_ctrl #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] op_rd,
  input  logic [ADDR_W-1:0] op_rs,
  input  logic [ADDR_W-1:0] op_rt,
  input  logic              imm_en,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              done_valid,
  output logic [ADDR_W-1:0] done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              zero_flag,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  import alu_pkg::*;

  state_t state_q, state_d;

  logic [DATA_W-1:0] x_q, y_q, res_q;
  logic [1:0]        sel_q;
  logic [ADDR_W-1:0] rd_q;
  logic              z_q, zero_q;

  logic [DATA_W-1:0] rs_data, rt_data;
  logic              accept;
  logic              rf_we;

  regfile_4x8 #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (op_rs),
    .ra_data (rs_data),
    .rb_addr (op_rt),
    .rb_data (rt_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .we      (rf_we),
    .wa      (rd_q),
    .wd      (res_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    op_ready   = 1'b0;
    done_valid = 1'b0;
    rf_we      = 1'b0;
    case (state_q)
      ST_IDLE: op_ready = 1'b1;
      ST_WB: begin
        done_valid = 1'b1;
        rf_we      = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = op_valid & op_ready;

  // Operand, result and flag registers. x/y/sel and rd/res are only
  // reloaded on accept / in EXEC, so the ALU and done_* outputs can be
  // driven straight from them and naturally hold their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      sel_q  <= '0;
      rd_q   <= '0;
      res_q  <= '0;
      z_q    <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_q   <= rs_data;
            y_q   <= imm_en ? imm : rt_data;
            sel_q <= op_code;
            rd_q  <= op_rd;
          end
        end
        ST_EXEC: begin
          res_q <= alu_result;
          z_q   <= alu_zero;
        end
        ST_WB: zero_q <= z_q;
        default: ;
      endcase
    end
  end

  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_sel   = sel_q;
  assign done_rd   = rd_q;
  assign done_data = res_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic [1:0] op_rd, op_rs, op_rt;
  logic       imm_en;
  logic [7:0] imm;
  logic [7:0] alu_x, alu_y;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       done_valid;
  logic [1:0] done_rd;
  logic [7:0] done_data;
  logic       zero_flag;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: plain array of register values plus the zero flag.
  int model_reg [4];
  int model_zf;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(8), .NREGS(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_rd(op_rd), .op_rs(op_rs), .op_rt(op_rt),
    .imm_en(imm_en), .imm(imm),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data),
    .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu #(.DATA_W(8)) u_alu (
    .x(alu_x), .y(alu_y), .sel(alu_sel),
    .result(alu_result), .zero(alu_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    op_valid = 1'($urandom);
    op_code  = 2'($urandom);
    op_rd    = 2'($urandom);
    op_rs    = 2'($urandom);
    op_rt    = 2'($urandom);
    imm_en   = 1'($urandom);
    imm      = 8'($urandom);
  endtask

  function automatic int ref_result(input int code, input int x, input int y);
    int r;
    case (code)
      0: r = x + y;
      1: r = x - y + 256;
      2: r = x & y;
      default: r = x | y;
    endcase
    return r % 256;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 4; i++) model_reg[i] = 0;
    model_zf = 0;
  endtask

  // Issues one op from an IDLE cycle and follows it through EXEC and WB.
  // noise: randomise op inputs while busy; hold: leave op_valid high at the end.
  task automatic do_op(input int code, input int rd, input int rs, input int rt,
                       input int ie, input int im, input bit noise, input bit hold);
    int x, y, r;
    x = model_reg[rs];
    y = (ie != 0) ? im : model_reg[rt];
    r = ref_result(code, x, y);
    op_valid = 1'b1;
    op_code  = 2'(code);
    op_rd    = 2'(rd);
    op_rs    = 2'(rs);
    op_rt    = 2'(rt);
    imm_en   = 1'(ie);
    imm      = 8'(im);
    dbg_addr = 2'(rd);
    #1;
    chk("idle_ready", 32'(op_ready), 32'd1);
    chk("idle_done_valid", 32'(done_valid), 32'd0);
    tick();                              // EXEC
    if (noise) scramble();
    #1;
    chk("exec_ready", 32'(op_ready), 32'd0);
    chk("exec_alu_x", 32'(alu_x), 32'(x));
    chk("exec_alu_y", 32'(alu_y), 32'(y));
    chk("exec_alu_sel", 32'(alu_sel), 32'(code));
    chk("exec_done_valid", 32'(done_valid), 32'd0);
    tick();                              // WB
    if (noise) scramble();
    if (!hold) op_valid = 1'b0;
    #1;
    chk("wb_ready", 32'(op_ready), 32'd0);
    chk("wb_done_valid", 32'(done_valid), 32'd1);
    chk("wb_done_rd", 32'(done_rd), 32'(rd));
    chk("wb_done_data", 32'(done_data), 32'(r));
    chk("wb_dbg_old", 32'(dbg_data), 32'(model_reg[rd]));
    tick();                              // back in IDLE
    model_reg[rd] = r;
    model_zf = (r == 0) ? 1 : 0;
    if (!hold) op_valid = 1'b0;
    #1;
    chk("post_ready", 32'(op_ready), 32'd1);
    chk("post_done_valid", 32'(done_valid), 32'd0);
    chk("post_dbg_new", 32'(dbg_data), 32'(r));
    chk("post_zero_flag", 32'(zero_flag), 32'(model_zf));
    chk("post_done_rd_hold", 32'(done_rd), 32'(rd));
    chk("post_done_data_hold", 32'(done_data), 32'(r));
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk(tag, 32'(dbg_data), 32'(model_reg[i]));
    end
  endtask

  initial begin
    rst = 1'b1;
    op_valid = 1'b0; op_code = '0; op_rd = '0; op_rs = '0; op_rt = '0;
    imm_en = 1'b0; imm = '0; dbg_addr = '0;
    reset_model();
    repeat (3) tick();
    rst = 1'b0;
    #1;

    // Reset then idle
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_zero_flag", 32'(zero_flag), 32'd0);
    chk("rst_alu_x", 32'(alu_x), 32'd0);
    chk("rst_alu_y", 32'(alu_y), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_done_rd", 32'(done_rd), 32'd0);
    chk("rst_done_data", 32'(done_data), 32'd0);
    check_all_regs("rst_reg");

    // Immediate ADD: reg1 = 0 + 5
    do_op(0, 1, 0, 0, 1, 8'h05, 1'b0, 1'b0);
    // Setup reg2 = 6, then SUB wrap and SUB to zero
    do_op(0, 2, 0, 0, 1, 8'h06, 1'b0, 1'b0);
    do_op(1, 3, 1, 2, 0, 8'hAA, 1'b0, 1'b0);
    chk("sub_wrap_reg3", 32'(model_reg[3]), 32'hFF);
    do_op(1, 0, 1, 1, 0, 8'h00, 1'b0, 1'b0);
    chk("sub_zero_flag", 32'(zero_flag), 32'd1);

    // Back-to-back dependency with op_valid held high
    do_op(0, 1, 0, 0, 1, 8'h0F, 1'b0, 1'b0);
    do_op(3, 1, 1, 0, 1, 8'hF0, 1'b0, 1'b1);
    do_op(2, 2, 1, 0, 1, 8'h3C, 1'b0, 1'b0);
    check_all_regs("b2b_reg");

    // Valid toggling while busy
    do_op(0, 3, 2, 1, 0, 8'h00, 1'b1, 1'b0);

    // Reset mid-op: assert during EXEC
    op_valid = 1'b1; op_code = 2'd0; op_rd = 2'd2; op_rs = 2'd0;
    imm_en = 1'b1; imm = 8'h77; dbg_addr = 2'd2;
    tick();                              // EXEC
    op_valid = 1'b0;
    rst = 1'b1;
    tick();                              // edge under reset
    reset_model();
    chk("midrst_done_valid", 32'(done_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_done_valid2", 32'(done_valid), 32'd0);
    chk("midrst_ready", 32'(op_ready), 32'd1);
    chk("midrst_alu_x", 32'(alu_x), 32'd0);
    chk("midrst_alu_y", 32'(alu_y), 32'd0);
    chk("midrst_done_data", 32'(done_data), 32'd0);
    chk("midrst_zero_flag", 32'(zero_flag), 32'd0);
    check_all_regs("midrst_reg");

    // Reset has priority over a same-cycle handshake
    do_op(0, 1, 0, 0, 1, 8'h11, 1'b0, 1'b0);
    op_valid = 1'b1; op_rd = 2'd2; imm = 8'h22; imm_en = 1'b1;
    rst = 1'b1;
    tick();
    reset_model();
    rst = 1'b0;
    op_valid = 1'b0;
    tick();
    chk("rstpri_ready", 32'(op_ready), 32'd1);
    chk("rstpri_done_valid", 32'(done_valid), 32'd0);
    check_all_regs("rstpri_reg");

    // Randomised ops against the reference model
    for (int n = 0; n < 40; n++) begin
      do_op(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
            int'($urandom_range(3)), int'($urandom_range(1)), int'($urandom_range(255)),
            1'($urandom), 1'($urandom));
    end
    op_valid = 1'b0;
    check_all_regs("final_reg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
